// File: rtl/iterative_multiplier_pkg.sv
// Shared M-extension definitions: operand width, counter width and function3 decoding.
// The iterative divider imports this same package.
package iterative_multiplier_pkg;

  localparam int MEXT_INPUT_WIDTH = 32;
  localparam int MEXT_COUNT_WIDTH = $clog2(MEXT_INPUT_WIDTH) + 1;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011
  } mul_funct3_e;

  typedef struct packed {
    logic sign_a;
    logic sign_b;
    logic high_half;
  } mul_ctrl_t;

  // MULHSU is the only mixed-sign form: signed multiplicand, unsigned multiplier.
  function automatic mul_ctrl_t decode_mul(input mul_funct3_e funct3);
    mul_ctrl_t ctrl;
    ctrl = '{sign_a: 1'b0, sign_b: 1'b0, high_half: 1'b0};
    case (funct3)
      F3_MULH:   ctrl = '{sign_a: 1'b1, sign_b: 1'b1, high_half: 1'b1};
      F3_MULHSU: ctrl = '{sign_a: 1'b1, sign_b: 1'b0, high_half: 1'b1};
      F3_MULHU:  ctrl = '{sign_a: 1'b0, sign_b: 1'b0, high_half: 1'b1};
      default:   ctrl = '{sign_a: 1'b1, sign_b: 1'b1, high_half: 1'b0};
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/iterative_multiplier_if.sv
// START/STALL/READY handshake bundle shared by the multiplier and its M-unit controller.
interface iterative_multiplier_if
  import iterative_multiplier_pkg::*;
#(
  parameter int INPUT_WIDTH = MEXT_INPUT_WIDTH
);

  logic                       STALL_MUL;
  logic                       START;
  logic                       SIGN_A;
  logic                       SIGN_B;
  logic [INPUT_WIDTH-1:0]     MULTIPLICAND;
  logic [INPUT_WIDTH-1:0]     MULTIPLIER;
  logic [2*INPUT_WIDTH-1:0]   PRODUCT_OUT;
  logic                       READY;

  modport master (
    output STALL_MUL, START, SIGN_A, SIGN_B, MULTIPLICAND, MULTIPLIER,
    input  PRODUCT_OUT, READY
  );

  modport slave (
    input  STALL_MUL, START, SIGN_A, SIGN_B, MULTIPLICAND, MULTIPLIER,
    output PRODUCT_OUT, READY
  );

endinterface

// File: rtl/iterative_multiplier_twos_magnitude.sv
// Conditional two's-complement negate; used for operand magnitudes and for
// restoring the sign of the final product.
module iterative_multiplier_twos_magnitude #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  assign data_out = en ? (~data_in + WIDTH'(1)) : data_in;

endmodule

// File: rtl/iterative_multiplier.sv
// Radix-2 shift-and-add multiplier producing the full 2W-bit product in W enabled cycles.
// Signed operands are multiplied as magnitudes and the sign is reapplied on the last step.
module iterative_multiplier
  import iterative_multiplier_pkg::*;
#(
  parameter int INPUT_WIDTH = MEXT_INPUT_WIDTH
) (
  input logic                  CLK,
  input logic                  RSTN,
  iterative_multiplier_if.slave mul_bus
);

  localparam int W           = INPUT_WIDTH;
  localparam int COUNT_WIDTH = $clog2(W) + 1;

  logic [COUNT_WIDTH-1:0] count;
  logic [2*W-1:0]         acc;
  logic [2*W-1:0]         mcand;
  logic [W-1:0]           mplier;
  logic                   neg;
  logic [2*W-1:0]         product_q;

  logic           neg_a;
  logic           neg_b;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic [2*W-1:0] acc_next;
  logic [2*W-1:0] product_signed;

  assign neg_a    = mul_bus.SIGN_A & mul_bus.MULTIPLICAND[W-1];
  assign neg_b    = mul_bus.SIGN_B & mul_bus.MULTIPLIER[W-1];
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  iterative_multiplier_twos_magnitude #(.WIDTH(W)) u_mag_a (
    .en       (neg_a),
    .data_in  (mul_bus.MULTIPLICAND),
    .data_out (mag_a)
  );

  iterative_multiplier_twos_magnitude #(.WIDTH(W)) u_mag_b (
    .en       (neg_b),
    .data_in  (mul_bus.MULTIPLIER),
    .data_out (mag_b)
  );

  iterative_multiplier_twos_magnitude #(.WIDTH(2*W)) u_sign_fix (
    .en       (neg),
    .data_in  (acc_next),
    .data_out (product_signed)
  );

  // A stall freezes everything, including a pending START; START otherwise
  // overrides any operation still in flight.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      neg       <= 1'b0;
      product_q <= '0;
    end else if (!mul_bus.STALL_MUL) begin
      if (mul_bus.START) begin
        count     <= COUNT_WIDTH'(W);
        acc       <= '0;
        mcand     <= {{W{1'b0}}, mag_a};
        mplier    <= mag_b;
        neg       <= neg_a ^ neg_b;
        product_q <= '0;
      end else if (count != '0) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count - COUNT_WIDTH'(1);
        if (count == COUNT_WIDTH'(1)) begin
          product_q <= product_signed;
        end
      end
    end
  end

  assign mul_bus.READY       = (count == '0);
  assign mul_bus.PRODUCT_OUT = product_q;

endmodule
